// File: rtl/timer_counter_pkg.sv
// timer_counter_pkg: shared clock-select encodings, status bit positions and prescaler mask helper
// Ports: none (package)
package timer_counter_pkg;
  typedef enum logic [1:0] {
    CKS_DIV2  = 2'b00,
    CKS_DIV4  = 2'b01,
    CKS_DIV8  = 2'b10,
    CKS_DIV16 = 2'b11
  } cks_e;
  localparam int TSR_OVF_BIT = 0;
  localparam int TSR_UDF_BIT = 1;
  // Low (cks+1) bits set: the prescaler ticks when all of them are ones
  function automatic logic [15:0] cks_mask(input logic [1:0] cks);
    return 16'((17'd1 << ({1'b0, cks} + 3'd1)) - 17'd1);
  endfunction
endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: free-running divider producing a count tick every 2/4/8/16 PCLK edges
// Ports: PCLK clock, PRESET sync reset, Cks divider select, clear restarts the divide, tick count strobe
module timer_prescaler
  import timer_counter_pkg::*;
#(
  parameter int PRESC_WIDTH = 4
) (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic [1:0] Cks,
  input  logic       clear,
  output logic       tick
);
  logic [PRESC_WIDTH-1:0] presc;
  logic [PRESC_WIDTH-1:0] mask;
  assign mask = PRESC_WIDTH'(cks_mask(Cks));
  // Gating by clear keeps a stale presc value from ticking in the cycle the counter is disabled
  assign tick = ~clear & ((presc & mask) == mask);
  always_ff @(posedge PCLK)
    presc <= (PRESET | clear) ? '0 : presc + PRESC_WIDTH'(1);
endmodule

// File: rtl/timer_counter.sv
// timer_counter: TCNT up/down counter with prescaled tick, wrap pulses and sticky wrap flags
// Ports: PCLK clock, PRESET sync reset, Cks divider select, Load_Tdr/count_start_value load,
//        count_up_down direction, count_enable run, ovf_clr/udf_clr flag clears,
//        TCNT count, ovf_pulse/udf_pulse wrap strobes, ovf_flag/udf_flag sticky status
module timer_counter
  import timer_counter_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int PRESC_WIDTH = 4
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic [1:0]            Cks,
  input  logic                  Load_Tdr,
  input  logic [DATA_WIDTH-1:0] count_start_value,
  input  logic                  count_up_down,
  input  logic                  count_enable,
  input  logic                  ovf_clr,
  input  logic                  udf_clr,
  output logic [DATA_WIDTH-1:0] TCNT,
  output logic                  ovf_pulse,
  output logic                  udf_pulse,
  output logic                  ovf_flag,
  output logic                  udf_flag
);
  logic       tick;
  logic       step;
  logic [1:0] set;
  logic [1:0] clr;
  logic [1:0] status;
  timer_prescaler #(.PRESC_WIDTH(PRESC_WIDTH)) u_presc (
    .PCLK  (PCLK),
    .PRESET(PRESET),
    .Cks   (Cks),
    .clear (Load_Tdr | ~count_enable),
    .tick  (tick)
  );
  // A load always beats a coinciding tick, so it also suppresses any wrap report
  assign step = tick & ~Load_Tdr;
  assign set[TSR_OVF_BIT] = step & ~count_up_down & (&TCNT);
  assign set[TSR_UDF_BIT] = step & count_up_down & ~(|TCNT);
  assign clr[TSR_OVF_BIT] = ovf_clr;
  assign clr[TSR_UDF_BIT] = udf_clr;
  assign ovf_flag = status[TSR_OVF_BIT];
  assign udf_flag = status[TSR_UDF_BIT];
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      TCNT      <= '0;
      ovf_pulse <= 1'b0;
      udf_pulse <= 1'b0;
      status    <= '0;
    end else begin
      TCNT      <= Load_Tdr ? count_start_value :
                   !step ? TCNT :
                   count_up_down ? TCNT - DATA_WIDTH'(1) : TCNT + DATA_WIDTH'(1);
      ovf_pulse <= set[TSR_OVF_BIT];
      udf_pulse <= set[TSR_UDF_BIT];
      status    <= set | (status & ~clr);
    end
  end
endmodule
